// File: rtl/simple_pkg.sv
`default_nettype none
//==============================================================================
// Module      : simple_pkg
// Description : Shared definitions for the 16-bit SIMPLE core: instruction
//               width, opcode field constants, the fetch state encoding and a
//               helper that recognises the HLT instruction.
// Revision    : 1.0 - initial release
//==============================================================================
package simple_pkg;

    localparam int INSTR_W = 16;

    // op1 field, instr[15:14]
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op3 field of ALU-class instructions, instr[7:4]
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] ins);
        return (ins[15:14] == OP1_ALU) && (ins[7:4] == OP3_HLT);
    endfunction

endpackage : simple_pkg
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
//==============================================================================
// Module      : fetch_skid
// Description : One-entry holding register for a fetched {instr, pc} pair.
//               Catches read data that returns while the output stage is
//               stalled. Flush wins over push/pop; push together with pop
//               replaces the entry and keeps it full.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               i_push/i_pop      - write / release the entry
//               i_flush           - discard the entry
//               i_instr/i_pc      - data to store
//               o_full            - entry holds valid data
//               o_instr/o_pc      - stored data
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_skid
    import simple_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_full,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_full;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else begin
            if (i_flush) begin
                r_full <= 1'b0;
            end else if (i_push) begin
                r_full <= 1'b1;
            end else if (i_pop) begin
                r_full <= 1'b0;
            end

            if (i_push && !i_flush) begin
                r_instr <= i_instr;
                r_pc    <= i_pc;
            end
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : fetch_skid
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
//==============================================================================
// Module      : instr_fetch
// Description : Instruction fetch front end for the SIMPLE core. Walks the PC
//               through a synchronous-read instruction memory and presents one
//               instruction per cycle, tagged with its address, to decode over
//               a valid/stall handshake. Handles branch redirects, stops on an
//               accepted HLT and restarts from IDLE/HALT on exec.
// Ports       : clock, reset              - clock, async active-low reset
//               exec                      - start / resume request
//               stall                     - decode cannot accept this cycle
//               redirect, redirect_pc     - taken branch and its target
//               imem_en, imem_addr        - memory read strobe and address
//               imem_rdata                - read data, one cycle after imem_en
//               instr, instr_pc           - presented instruction and address
//               instr_valid               - instr is live
//               halted                    - fetch is in HALT
// Revision    : 1.0 - initial release
//==============================================================================
module instr_fetch
    import simple_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_pend;       // read issued last cycle, data on imem_rdata now
    logic [ADDR_W-1:0]  r_pend_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;

    logic               w_accept;
    logic               w_hlt_acc;
    logic               w_issue;
    logic               w_squash;
    logic               w_out_free;
    logic               w_load_skid;
    logic               w_load_ret;
    logic               w_skid_push;
    logic               w_skid_pop;
    logic               w_skid_full;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next state, issue and handshake decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hlt_acc   = 1'b0;
        w_issue     = 1'b0;
        w_accept    = r_out_valid && !stall;

        case (r_state)
            FETCH_IDLE, FETCH_HALT: begin
                // A redirect here only reloads the PC, so it masks exec.
                if (!redirect && exec) begin
                    w_state_nxt = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (redirect) begin
                    w_state_nxt = FETCH_RUN;
                end else if (w_accept && is_hlt(r_out_instr)) begin
                    w_hlt_acc   = 1'b1;
                    w_state_nxt = FETCH_HALT;
                end else begin
                    // Under stall at most one more word may be in flight:
                    // it either lands in the skid or the skid is already used.
                    w_issue = !(stall && (r_pend || w_skid_full));
                end
            end
            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase
    end

    // Redirect and an accepted HLT both discard everything behind the output.
    assign w_squash = (r_state == FETCH_RUN) && (redirect || w_hlt_acc);

    // Output slot can take new data when empty or being accepted; the skid
    // entry is older than returning data, so it goes first.
    assign w_out_free  = !r_out_valid || w_accept;
    assign w_load_skid = !w_squash && w_out_free && w_skid_full;
    assign w_load_ret  = !w_squash && w_out_free && !w_skid_full && r_pend;
    assign w_skid_pop  = w_load_skid;
    assign w_skid_push = !w_squash && r_pend && (!w_out_free || w_skid_full);

    fetch_skid #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_flush (w_squash),
        .i_instr (imem_rdata),
        .i_pc    (r_pend_pc),
        .o_full  (w_skid_full),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    //--------------------------------------------------------------------------
    // PC, pending read and output register
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc        <= c_reset_pc;
            r_pend      <= 1'b0;
            r_pend_pc   <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_hlt_acc) begin
                // Resume point is the word after the HLT, not the read-ahead PC.
                r_pc <= r_out_pc + 1'b1;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end

            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_pc <= r_pc;
            end

            if (w_squash) begin
                r_out_valid <= 1'b0;
            end else if (w_out_free) begin
                r_out_valid <= w_load_skid || w_load_ret;
            end

            if (w_load_skid) begin
                r_out_instr <= w_skid_instr;
                r_out_pc    <= w_skid_pc;
            end else if (w_load_ret) begin
                r_out_instr <= imem_rdata;
                r_out_pc    <= r_pend_pc;
            end
        end
    end

    assign imem_en     = w_issue;
    assign imem_addr   = r_pc;
    assign instr       = r_out_valid ? r_out_instr : '0;
    assign instr_pc    = r_out_pc;
    assign instr_valid = r_out_valid;
    assign halted      = (r_state == FETCH_HALT);

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A queue-based model of
//               the fetch stream predicts every output each cycle; directed
//               sequences pin start-up latency, stall hold, redirect bubble,
//               HLT/resume, mid-run reset and PC wrap on a 4-bit build.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_instr_fetch;

    localparam int AW  = 12;
    localparam int AW4 = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main DUT
    logic          reset, exec, stall, redirect;
    logic [AW-1:0] redirect_pc;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic [15:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid, halted;

    // 4-bit address build
    logic           reset4, exec4, stall4, redirect4;
    logic [AW4-1:0] redirect_pc4;
    logic           imem_en4;
    logic [AW4-1:0] imem_addr4;
    logic [15:0]    imem_rdata4;
    logic [15:0]    instr4;
    logic [AW4-1:0] instr_pc4;
    logic           instr_valid4, halted4;

    logic [15:0] mem  [0:(1<<AW)-1];
    logic [15:0] mem4 [0:(1<<AW4)-1];

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset), .exec(exec), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .halted(halted)
    );

    instr_fetch #(.ADDR_W(AW4), .RESET_PC(0)) dut4 (
        .clock(clock), .reset(reset4), .exec(exec4), .stall(stall4),
        .redirect(redirect4), .redirect_pc(redirect_pc4),
        .imem_en(imem_en4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
        .instr(instr4), .instr_pc(instr_pc4), .instr_valid(instr_valid4),
        .halted(halted4)
    );

    // Synchronous-read memories; garbage on non-read cycles.
    always @(posedge clock) imem_rdata  <= imem_en  ? mem[imem_addr]   : 16'($urandom);
    always @(posedge clock) imem_rdata4 <= imem_en4 ? mem4[imem_addr4] : 16'($urandom);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit hlt_word(input logic [15:0] w);
        return (w[15:14] == 2'b11) && (w[7:4] == 4'hf);
    endfunction

    //--------------------------------------------------------------------------
    // Reference model: queue of fetched words, each usable from issue+2.
    // States: 0 idle, 1 run, 2 halt.
    //--------------------------------------------------------------------------
    int cyc     = 0;
    int m_state = 0;
    int m_pc    = 0;
    int q_pc[$];
    int q_av[$];

    always @(negedge clock) begin : p_cmp
        bit          hv, pend, acc, hl, en;
        int          arrived;
        logic [15:0] ein;
        if (!reset) begin
            check("rst_valid",  instr_valid, 0);
            check("rst_instr",  instr,       0);
            check("rst_pc",     instr_pc,    0);
            check("rst_en",     imem_en,     0);
            check("rst_addr",   imem_addr,   0);
            check("rst_halted", halted,      0);
            m_state = 0;
            m_pc    = 0;
            q_pc.delete();
            q_av.delete();
        end else begin
            hv      = (q_pc.size() > 0) && (q_av[0] <= cyc);
            ein     = hv ? mem[q_pc[0]] : 16'h0;
            arrived = 0;
            pend    = 1'b0;
            foreach (q_av[k]) begin
                if (q_av[k] <= cyc) arrived++;
                if (q_av[k] == cyc + 1) pend = 1'b1;
            end
            acc = hv && !stall;
            hl  = acc && hlt_word(ein);
            en  = (m_state == 1) && !redirect && !hl && !(stall && (pend || arrived >= 2));

            check("valid",  instr_valid, hv);
            check("instr",  instr,       ein);
            if (hv) check("instr_pc", instr_pc, q_pc[0]);
            check("imem_en", imem_en, en);
            if (en) check("imem_addr", imem_addr, m_pc);
            check("halted", halted, m_state == 2);

            if (m_state == 1) begin
                if (redirect) begin
                    q_pc.delete(); q_av.delete();
                    m_pc = int'(redirect_pc);
                end else if (hl) begin
                    m_pc = (q_pc[0] + 1) % (1 << AW);
                    q_pc.delete(); q_av.delete();
                    m_state = 2;
                end else begin
                    if (acc) begin
                        void'(q_pc.pop_front());
                        void'(q_av.pop_front());
                    end
                    if (en) begin
                        q_pc.push_back(m_pc);
                        q_av.push_back(cyc + 2);
                        m_pc = (m_pc + 1) % (1 << AW);
                    end
                end
            end else begin
                if (redirect) m_pc = int'(redirect_pc);
                else if (exec) m_state = 1;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pc(input int pc, input int limit);
        int k = 0;
        while (!(instr_valid && int'(instr_pc) == pc) && k < limit) begin
            step();
            k++;
        end
        check("reach_valid", instr_valid, 1);
        check("reach_pc",    instr_pc,    pc);
    endtask

    //--------------------------------------------------------------------------
    // 4-bit build: PC wraps 14, 15, 0, 1
    //--------------------------------------------------------------------------
    initial begin : p_wrap
        reset4 = 1'b0; exec4 = 1'b0; stall4 = 1'b0; redirect4 = 1'b0; redirect_pc4 = '0;
        for (int i = 0; i < (1 << AW4); i++) mem4[i] = 16'(16'h2000 + i);
        repeat (3) @(posedge clock);
        #1 reset4 = 1'b1;
        redirect4 = 1'b1; redirect_pc4 = 4'd14;
        step();
        redirect4 = 1'b0;
        exec4 = 1'b1;
        step();
        exec4 = 1'b0;
        step();
        step();
        check("w4_valid0", instr_valid4, 1); check("w4_pc0", instr_pc4, 14); check("w4_i0", instr4, 16'h200e);
        step();
        check("w4_valid1", instr_valid4, 1); check("w4_pc1", instr_pc4, 15); check("w4_i1", instr4, 16'h200f);
        step();
        check("w4_valid2", instr_valid4, 1); check("w4_pc2", instr_pc4, 0);  check("w4_i2", instr4, 16'h2000);
        step();
        check("w4_valid3", instr_valid4, 1); check("w4_pc3", instr_pc4, 1);  check("w4_i3", instr4, 16'h2001);
    end

    //--------------------------------------------------------------------------
    // Main stimulus
    //--------------------------------------------------------------------------
    initial begin : p_stim
        reset = 1'b0; exec = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(16'h1000 + i);

        step();
        check("r0_valid", instr_valid, 0);
        check("r0_halt",  halted,      0);
        step();
        reset = 1'b1;
        step();

        // start-up latency: exec sampled at edge t, first word after edge t+2
        exec = 1'b1;
        step();
        exec = 1'b0;
        check("start_t0", instr_valid, 0);
        step();
        check("start_t1", instr_valid, 0);
        step();
        check("start_valid", instr_valid, 1);
        check("start_instr", instr,       16'h1000);
        check("start_pc",    instr_pc,    0);
        step();
        check("next_pc",    instr_pc, 1);
        check("next_instr", instr,    16'h1001);

        // three-cycle stall on pc 5
        wait_pc(5, 20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_pc", instr_pc, 5);
        end
        stall = 1'b0;
        step();
        check("release_pc6", instr_pc, 6);
        step();
        check("release_pc7", instr_pc, 7);

        // redirect while stalled on pc 9
        wait_pc(9, 20);
        stall = 1'b1;
        step();
        check("redir_hold", instr_pc, 9);
        redirect = 1'b1; redirect_pc = 12'h040;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("redir_drop", instr_valid, 0);
        step();
        check("redir_bubble", instr_valid, 0);
        step();
        check("redir_valid", instr_valid, 1);
        check("redir_pc",    instr_pc,    12'h040);
        check("redir_instr", instr,       16'h1040);

        // HLT at address 3, then resume
        step();
        mem[3] = 16'hc0f0;
        redirect = 1'b1; redirect_pc = 12'h000;
        step();
        redirect = 1'b0;
        wait_pc(3, 20);
        check("hlt_word", instr, 16'hc0f0);
        step();
        check("hlt_halted", halted,      1);
        check("hlt_drop",   instr_valid, 0);
        repeat (4) step();
        exec = 1'b1;
        step();
        exec = 1'b0;
        step();
        step();
        check("resume_valid", instr_valid, 1);
        check("resume_pc",    instr_pc,    4);
        check("resume_instr", instr,       16'h1004);

        // asynchronous reset while stalled with the skid occupied
        step();
        stall = 1'b1;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_instr", instr,       0);
        check("mid_rst_pc",    instr_pc,    0);
        check("mid_rst_en",    imem_en,     0);
        check("mid_rst_addr",  imem_addr,   0);
        stall = 1'b0;
        step();
        step();
        reset = 1'b1;
        repeat (6) step();
        check("post_rst_idle", instr_valid, 0);

        // randomized run
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        exec = 1'b1;
        step();
        exec = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = 12'($urandom);
            exec        = ($urandom_range(0, 7) == 0);
            step();
        end
        stall = 1'b0; redirect = 1'b0; exec = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the 16-bit SIMPLE core. Walks the PC through a synchronous-read instruction memory and presents one 16-bit instruction per cycle, tagged with its address, to the decode/`controller` stage over a valid/stall handshake. Accepts branch redirects from execute and halts itself on `HLT`. Supports restart from idle or halt via `exec`.

## Interface
Parameters:
- `ADDR_W`, 12: instruction address width in words.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `exec`  in  1: one-cycle start/resume request.
- `stall`  in  1: decode cannot accept this cycle.
- `redirect`  in  1: taken branch from execute.
- `redirect_pc`  in  ADDR_W: branch target.
- `imem_en`  out  1: read strobe to instruction memory.
- `imem_addr`  out  ADDR_W: read address.
- `imem_rdata`  in  16: read data, valid exactly one cycle after `imem_en`.
- `instr`  out  16: instruction to decode; forced to 16'd0 when `instr_valid`=0.
- `instr_pc`  out  ADDR_W: address of `instr`.
- `instr_valid`  out  1: `instr` is live.
- `halted`  out  1: high in HALT state.

## Operation
- States: IDLE, RUN, HALT.
  - Reset: IDLE, `pc`=RESET_PC.
  - IDLE --`exec`--> RUN.
  - RUN --HLT accepted--> HALT.
  - HALT --`exec`--> RUN, resuming at HLT address + 1.
  - `exec` is ignored in RUN.
- HLT is `instr[15:14]`=2'b11 and `instr[7:4]`=4'b1111.
- Accept: a cycle with `instr_valid`=1 and `stall`=0.
- Issue (RUN only): `imem_en`=1, `imem_addr`=`pc`, `pc`<=`pc`+1 (mod 2^ADDR_W).
  - Issue is blocked when `stall`=1 and (read pending or skid full).
  - This bounds in-flight data to one read under stall.
- Return data:
  - Goes to the output register if it is empty or being accepted this cycle.
  - Otherwise it goes to the one-entry skid buffer.
  - While the output is being accepted, the skid entry (if any) moves to the output first, and return data then goes to the skid.
- `redirect` (RUN only), highest priority:
  - Clears `instr_valid`, the skid, and the pending read. Returning data for the squashed read is discarded.
  - Sets `pc`=`redirect_pc`; issue from the target starts the next cycle.
  - Overrides both `stall` and an HLT on the output in the same cycle.
- HLT accepted:
  - Clear the skid and pending read.
  - Issue no further reads.
  - `instr_valid` drops the next cycle.
- `redirect` in IDLE/HALT: loads `pc` only; state unchanged.
- Instruction 16'd0 passes as an ordinary instruction.

## Timing
- Reset values:
  - `imem_en`=0, `imem_addr`=RESET_PC.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0.
  - `halted`=0.
  - Skid empty, no pending read.
- `exec` at cycle t (IDLE): issue at t+1, `instr_valid` at t+2.
- Steady state: one instruction per cycle with `stall`=0.
- Redirect at t: `instr_valid`=0 at t+1; issue of `redirect_pc` at t+1; target valid at t+2 (2-cycle bubble).
- HLT accepted at t: `halted`=1 and `instr_valid`=0 from t+1.
- Stall release: skid entry is presented the cycle after release with no lost or duplicated instruction.
- `pc` wraps from 2^ADDR_W-1 to 0 silently.
- Asynchronous reset mid-operation returns all state to the reset values immediately; in-flight reads are dropped.

## Structure
- Shared package `simple_pkg` holds:
  - Opcode field constants: `OP1_LD`=2'b00, `OP1_BR`=2'b10, `OP1_ALU`=2'b11, `OP3_HLT`=4'b1111, `OP3_CMP`, `OP3_OUT`.
  - `INSTR_W`=16.
  - The fetch state enum.
- One sub-module, `fetch_skid`: a one-entry holding register for {instr, pc}, with push/pop/flush and a full flag.

## Test plan
- Reset, then `exec` with memory[i]=0x1000+i:
  - `instr`=0x1000 / `instr_pc`=0 at cycle 2.
  - Consecutive words every cycle.
- `stall` high for 3 cycles mid-stream at pc 5:
  - `instr_pc`=5 holds during the stall.
  - Sequence 5, 6, 7… after release with no gap, duplicate, or loss; skid used exactly once.
- `redirect` with `redirect_pc`=0x040 while stalled on pc 9:
  - Output drops next cycle.
  - `instr_pc`=0x040 two cycles after the redirect; the word at 10 never appears.
- HLT (0xC0F0) at address 3:
  - `halted`=1 after it is accepted; no `imem_en` afterwards.
  - `exec` resumes with `instr_pc`=4.
- ADDR_W=4 build:
  - `instr_pc` runs 14, 15, 0, 1.
- Reset asserted while a read is pending and the skid is full:
  - All outputs return to reset values; nothing appears after reset deasserts until `exec`.
